// File: rtl/fp32_add_normalize_round.sv
// ---------------------------------------------------------------------------
// fp32_add_normalize_round
//   Back end of the FP32 adder pipeline. Takes the add/sub stage output
//   (sign, raw 25-bit magnitude, larger biased exponent) and produces a
//   packed binary32 result. The work is leading-one detection, normalisation,
//   exponent adjust, round-to-nearest-even on the single dropped bit,
//   overflow saturation, flush-to-zero and packing.
//   Three register stages; one operation accepted per clock, no backpressure.
//
// Ports
//   clk            in   rising-edge clock
//   rstn           in   asynchronous active-low reset
//   valid_in       in   operation valid this cycle
//   sign_in        in   result sign from the add/sub stage
//   exp_in         in   biased exponent of the larger operand
//   adder_value    in   raw magnitude; [MAN_W+1] carry, [MAN_W] hidden-bit slot
//   special_in     in   NaN/Inf already resolved upstream; pass special_value
//   special_value  in   packed result used when special_in=1
//   valid_out      out  result valid, fixed 3 clocks after valid_in
//   result         out  packed {sign, exponent, fraction}
//   overflow       out  result saturated to infinity
//   underflow      out  nonzero result flushed to signed zero
// ---------------------------------------------------------------------------
module fp32_add_normalize_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int EXT_W = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   valid_in,
    input  logic                   sign_in,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic [MAN_W+1:0]       adder_value,
    input  logic                   special_in,
    input  logic [EXP_W+MAN_W:0]   special_value,
    output logic                   valid_out,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int SUM_W  = MAN_W + 2;
    localparam int SIG_W  = MAN_W + 1;
    localparam int LZ_W   = $clog2(SUM_W);
    localparam int WORD_W = 1 + EXP_W + MAN_W;

    localparam logic signed [EXT_W-1:0] EXP_ONE  = EXT_W'(1);
    localparam logic signed [EXT_W-1:0] EXP_ZERO = '0;
    localparam logic signed [EXT_W-1:0] EXP_MAX  = EXT_W'((1 << EXP_W) - 1);

    // ---------------- Stage 1: input registers + leading-zero count -------
    logic [LZ_W-1:0] w_lzc;

    // Ascending scan: the highest set bit is the last one to write w_lzc.
    // An all-zero low field leaves the count at SIG_W.
    always_comb begin
        w_lzc = '0;
        if (!adder_value[SUM_W-1]) begin
            w_lzc = LZ_W'(SIG_W);
            for (int unsigned i = 0; i < SIG_W; i++) begin
                if (adder_value[i]) begin
                    w_lzc = LZ_W'(MAN_W - i);
                end
            end
        end
    end

    logic                r_s1_valid;
    logic                r_s1_sign;
    logic [EXP_W-1:0]    r_s1_exp;
    logic [SUM_W-1:0]    r_s1_val;
    logic [LZ_W-1:0]     r_s1_lzc;
    logic                r_s1_special;
    logic [WORD_W-1:0]   r_s1_spval;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_val     <= '0;
            r_s1_lzc     <= '0;
            r_s1_special <= 1'b0;
            r_s1_spval   <= '0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_sign    <= sign_in;
                r_s1_exp     <= exp_in;
                r_s1_val     <= adder_value;
                r_s1_lzc     <= w_lzc;
                r_s1_special <= special_in;
                r_s1_spval   <= special_value;
            end
        end
    end

    // ---------------- Stage 2: normalise + exponent adjust ---------------
    logic signed [EXT_W-1:0] w_s2_exp_base;
    logic signed [EXT_W-1:0] w_s2_exp;
    logic [SIG_W-1:0]        w_s2_mant;
    logic                    w_s2_rnd;
    logic                    w_s2_zero;
    logic                    w_s2_sign;

    assign w_s2_exp_base = $signed({{(EXT_W-EXP_W){1'b0}}, r_s1_exp});

    always_comb begin
        w_s2_mant = '0;
        w_s2_rnd  = 1'b0;
        w_s2_exp  = w_s2_exp_base;
        w_s2_zero = 1'b0;
        w_s2_sign = r_s1_sign;
        if (r_s1_val[SUM_W-1]) begin
            w_s2_mant = r_s1_val[SUM_W-1:1];
            w_s2_rnd  = r_s1_val[0];
            w_s2_exp  = w_s2_exp_base + EXP_ONE;
        end else if (r_s1_val != '0) begin
            w_s2_mant = r_s1_val[SIG_W-1:0] << r_s1_lzc;
            w_s2_exp  = w_s2_exp_base - $signed({{(EXT_W-LZ_W){1'b0}}, r_s1_lzc});
        end else begin
            // exact cancellation always yields +0
            w_s2_zero = 1'b1;
            w_s2_sign = 1'b0;
        end
    end

    logic                    r_s2_valid;
    logic                    r_s2_sign;
    logic signed [EXT_W-1:0] r_s2_exp;
    logic [SIG_W-1:0]        r_s2_mant;
    logic                    r_s2_rnd;
    logic                    r_s2_zero;
    logic                    r_s2_special;
    logic [WORD_W-1:0]       r_s2_spval;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_valid   <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_exp     <= '0;
            r_s2_mant    <= '0;
            r_s2_rnd     <= 1'b0;
            r_s2_zero    <= 1'b0;
            r_s2_special <= 1'b0;
            r_s2_spval   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign    <= w_s2_sign;
                r_s2_exp     <= w_s2_exp;
                r_s2_mant    <= w_s2_mant;
                r_s2_rnd     <= w_s2_rnd;
                r_s2_zero    <= w_s2_zero;
                r_s2_special <= r_s1_special;
                r_s2_spval   <= r_s1_spval;
            end
        end
    end

    // ---------------- Stage 3: round, range check, pack ------------------
    logic                    w_inc;
    logic [SIG_W:0]          w_sum;
    logic [SIG_W-1:0]        w_mant_f;
    logic signed [EXT_W-1:0] w_exp_f;
    logic [WORD_W-1:0]       w_result;
    logic                    w_ovf;
    logic                    w_unf;

    // The dropped bit is a lone half ulp, so rnd=1 is always a tie:
    // round up only when that makes the kept LSB even.
    assign w_inc = r_s2_rnd & r_s2_mant[0];
    assign w_sum = {1'b0, r_s2_mant} + (SIG_W+1)'(w_inc);

    always_comb begin
        w_mant_f = w_sum[SIG_W-1:0];
        w_exp_f  = r_s2_exp;
        if (w_sum[SIG_W]) begin
            w_mant_f = w_sum[SIG_W:1];
            w_exp_f  = r_s2_exp + EXP_ONE;
        end
    end

    always_comb begin
        w_result = {r_s2_sign, w_exp_f[EXP_W-1:0], w_mant_f[MAN_W-1:0]};
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        if (r_s2_special) begin
            w_result = r_s2_spval;
        end else if (r_s2_zero) begin
            w_result = '0;
        end else if (w_exp_f >= EXP_MAX) begin
            w_result = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf    = 1'b1;
        end else if (w_exp_f <= EXP_ZERO) begin
            w_result = {r_s2_sign, {(EXP_W+MAN_W){1'b0}}};
            w_unf    = 1'b1;
        end
    end

    logic                r_s3_valid;
    logic [WORD_W-1:0]   r_s3_result;
    logic                r_s3_ovf;
    logic                r_s3_unf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s3_valid  <= 1'b0;
            r_s3_result <= '0;
            r_s3_ovf    <= 1'b0;
            r_s3_unf    <= 1'b0;
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_result <= w_result;
                r_s3_ovf    <= w_ovf;
                r_s3_unf    <= w_unf;
            end
        end
    end

    assign valid_out = r_s3_valid;
    assign result    = r_s3_result;
    assign overflow  = r_s3_ovf;
    assign underflow = r_s3_unf;

endmodule

// File: tb/tb_fp32_add_normalize_round.sv
// ---------------------------------------------------------------------------
// tb_fp32_add_normalize_round
//   Self-checking bench: a table of hand-computed vectors streamed
//   back-to-back, random vectors checked against a reference model, plus
//   hand sequences for latency, idle hold and mid-flight reset. Expected
//   results are queued when an operation is driven and popped when
//   valid_out appears.
// ---------------------------------------------------------------------------
module tb_fp32_add_normalize_round;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid_in = 1'b0;
    logic        sign_in = 1'b0;
    logic [7:0]  exp_in = '0;
    logic [24:0] adder_value = '0;
    logic        special_in = 1'b0;
    logic [31:0] special_value = '0;
    logic        valid_out;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    fp32_add_normalize_round #(
        .EXP_W (8),
        .MAN_W (23),
        .EXT_W (10)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .valid_in      (valid_in),
        .sign_in       (sign_in),
        .exp_in        (exp_in),
        .adder_value   (adder_value),
        .special_in    (special_in),
        .special_value (special_value),
        .valid_out     (valid_out),
        .result        (result),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [33:0] sb[$];
    logic [33:0] last_exp = '0;
    int          run_len  = 0;
    int          max_run  = 0;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [24:0] v;
        logic        sp;
        logic [31:0] spv;
        logic [31:0] res;
        logic        ov;
        logic        uf;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl[NVEC];

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got ov=%0b uf=%0b val=%08h, expected ov=%0b uf=%0b val=%08h",
                     name, got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
        end
    endtask

    // Reference: locate the MSB, scale, round the single dropped bit to even.
    function automatic logic [33:0] model(input logic s, input logic [7:0] e_in,
                                          input logic [24:0] v, input logic sp,
                                          input logic [31:0] spv);
        int          p;
        int          e;
        logic [25:0] m;
        if (sp) return {2'b00, spv};
        if (v == 25'd0) return '0;
        p = 0;
        for (int i = 0; i < 25; i++) if (v[i]) p = i;
        e = int'(e_in) + p - 23;
        if (p == 24) begin
            m = {2'b00, v[24:1]};
            if (v[0] && m[0]) m = m + 26'd1;
            if (m[24]) begin
                m = m >> 1;
                e = e + 1;
            end
        end else begin
            m = {1'b0, v} << (23 - p);
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
        if (e <= 0)   return {2'b01, s, 31'h0};
        return {2'b00, s, 8'(e), m[22:0]};
    endfunction

    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] v,
                        input logic sp, input logic [31:0] spv, input logic [33:0] expv);
        @(negedge clk);
        sign_in       = s;
        exp_in        = e;
        adder_value   = v;
        special_in    = sp;
        special_value = spv;
        valid_in      = 1'b1;
        sb.push_back(expv);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 34'(sb.size()), 34'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 8'd127, 25'h1000000, 1'b0, 32'h0,        32'h40000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'd127, 25'h0000001, 1'b0, 32'h0,        32'h34000000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'd127, 25'h1000003, 1'b0, 32'h0,        32'h40000002, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'd127, 25'h1000001, 1'b0, 32'h0,        32'h40000000, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'd127, 25'h1FFFFFF, 1'b0, 32'h0,        32'h40800000, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'd254, 25'h1000000, 1'b0, 32'h0,        32'h7F800000, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 8'd1,   25'h0000001, 1'b0, 32'h0,        32'h80000000, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 8'd100, 25'h0000000, 1'b0, 32'h0,        32'h00000000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'd254, 25'h1000000, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'd0,   25'h0800000, 1'b0, 32'h0,        32'h00000000, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'd0,   25'h1000000, 1'b0, 32'h0,        32'h00800000, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'd254, 25'h0FFFFFF, 1'b0, 32'h0,        32'h7F7FFFFF, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'd255, 25'h0400000, 1'b0, 32'h0,        32'h7F000000, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'd24,  25'h0000001, 1'b0, 32'h0,        32'h00800000, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 8'd23,  25'h0000001, 1'b0, 32'h0,        32'h80000000, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 8'd253, 25'h1FFFFFF, 1'b0, 32'h0,        32'hFF800000, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 8'd130, 25'h0C00000, 1'b0, 32'h0,        32'h41400000, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 8'd127, 25'h1000002, 1'b0, 32'h0,        32'hC0000001, 1'b0, 1'b0};

        fork
            forever begin
                @(negedge clk);
                if (rstn) begin
                    if (valid_out) begin
                        run_len++;
                        if (run_len > max_run) max_run = run_len;
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_valid_out: got val=%08h, expected no output", result);
                        end else begin
                            last_exp = sb.pop_front();
                            check("result", {overflow, underflow, result}, last_exp);
                        end
                    end else begin
                        run_len = 0;
                    end
                end
            end
            begin
                #1_000_000;
                $display("FAIL global_timeout: got no finish, expected finish");
                $fatal(1, "timeout");
            end
        join_none

        // reset state
        #12;
        check("reset_outputs", {overflow, underflow, result}, 34'd0);
        check("reset_valid", 34'(valid_out), 34'd0);
        @(negedge clk);
        rstn = 1'b1;

        // latency: output appears after exactly the third rising edge
        send(tbl[0].s, tbl[0].e, tbl[0].v, tbl[0].sp, tbl[0].spv, {tbl[0].ov, tbl[0].uf, tbl[0].res});
        idle(1);
        check("latency_c1", 34'(valid_out), 34'd0);
        idle(1);
        check("latency_c2", 34'(valid_out), 34'd0);
        idle(1);
        check("latency_c3", 34'(valid_out), 34'd1);

        // table vectors streamed back-to-back
        max_run = 0;
        for (int i = 0; i < NVEC; i++)
            send(tbl[i].s, tbl[i].e, tbl[i].v, tbl[i].sp, tbl[i].spv,
                 {tbl[i].ov, tbl[i].uf, tbl[i].res});
        drain();
        check("stream_no_bubbles", 34'(max_run), 34'(NVEC));

        // random vectors with occasional gaps
        for (int i = 0; i < 40; i++) begin
            logic [24:0] v;
            logic [7:0]  e;
            logic        s;
            logic        sp;
            logic [31:0] spv;
            case ($urandom_range(0, 3))
                0:       v = 25'($urandom);
                1:       v = 25'($urandom) | 25'h1000000;
                2:       v = 25'($urandom_range(0, 255));
                default: v = 25'($urandom) & 25'h0FFFFFF;
            endcase
            e   = 8'($urandom);
            s   = 1'($urandom);
            sp  = ($urandom_range(0, 15) == 0);
            spv = $urandom;
            send(s, e, v, sp, spv, model(s, e, v, sp, spv));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // idle hold: outputs keep the last result while valid_out stays low
        send(tbl[16].s, tbl[16].e, tbl[16].v, tbl[16].sp, tbl[16].spv,
             {tbl[16].ov, tbl[16].uf, tbl[16].res});
        drain();
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("idle_hold", {overflow, underflow, result}, {tbl[16].ov, tbl[16].uf, tbl[16].res});
            check("idle_valid", 34'(valid_out), 34'd0);
        end

        // reset with two operations in flight
        send(tbl[4].s, tbl[4].e, tbl[4].v, 1'b0, 32'h0, 34'd0);
        send(tbl[5].s, tbl[5].e, tbl[5].v, 1'b0, 32'h0, 34'd0);
        @(negedge clk);
        valid_in = 1'b0;
        rstn     = 1'b0;
        sb.delete();
        #1;
        check("midreset_outputs", {overflow, underflow, result}, 34'd0);
        check("midreset_valid", 34'(valid_out), 34'd0);
        @(negedge clk);
        rstn = 1'b1;
        begin
            int ghosts = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (valid_out) ghosts++;
            end
            check("midreset_no_ghost", 34'(ghosts), 34'd0);
        end

        // pipeline works again after reset
        send(tbl[2].s, tbl[2].e, tbl[2].v, 1'b0, 32'h0, {tbl[2].ov, tbl[2].uf, tbl[2].res});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
